// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART 8N1 receiver, LSB first; RX_PARITY_EN adds an 8E1/8O1 parity stage
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          rxd_m;
    logic          rxd_s;

`ifdef RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic par_bad;
    logic par_err_q;
    assign parity_err = par_err_q;
`else
    // Parity polarity only matters when the parity stage is built in.
    localparam logic unused_parity_odd = (PARITY_ODD != 0);
    assign parity_err = 1'b0;
`endif

    assign rx_busy = (state != S_IDLE);

    // Two-flop synchroniser for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // Frame state machine: midpoint sampling, byte assembly and single-cycle result pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            par_bad   <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        idx   <= '0;
                        // A line back high at the start midpoint was only a glitch.
                        state <= rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {rxd_s, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef RX_PARITY_EN
                S_PARITY: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        par_bad <= ((^shreg) ^ rxd_s) != PAR_ODD;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
`ifdef RX_PARITY_EN
                        else if (par_bad) begin
                            par_err_q <= 1'b1;
                            state     <= S_IDLE;
                        end
`endif
                        else begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    cnt <= '0;
                    if (rxd_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int PODD = 0;
`ifdef RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int LAT = 3 + CPB / 2 + (NBITS - 1) * CPB;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int overlap = 0;
    int busy_run = 0;
    int max_busy = 0;
    int last_start = 0;
    logic [7:0] vld_q[$];
    int         vld_cyc[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .PARITY_ODD  (PODD)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and busy monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            vld_cnt++;
            vld_q.push_back(rx_data);
            vld_cyc.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (parity_err) perr_cnt++;
        if (int'(rx_valid) + int'(frame_err) + int'(parity_err) > 1) overlap++;
        if (rx_busy) begin
            busy_run++;
            if (busy_run > max_busy) max_busy = busy_run;
        end else begin
            busy_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        last_start = cyc;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
`ifdef RX_PARITY_EN
        rxd = (^b) ^ (PODD != 0);
        tick(CPB);
`endif
        rxd = stop_bit;
        tick(CPB);
    endtask

`ifdef RX_PARITY_EN
    task automatic send_frame_p(input logic [7:0] b, input logic par);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = par;
        tick(CPB);
        rxd = 1'b1;
        tick(CPB);
    endtask
`endif

    initial begin
        int base;
        int d;
        logic [7:0] b3c;

        // Reset state
        tick(3);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        n_rst = 1'b1;
        tick(5);

        // 1: single frame 0x55
        base = vld_cnt;
        send_frame(8'h55, 1'b1);
        tick(4);
        check("t1_count", vld_cnt - base, 1);
        check("t1_data", rx_data, 8'h55);
        check("t1_ferr", ferr_cnt, 0);
        check("t1_perr", perr_cnt, 0);
        check("t1_busy", rx_busy, 1'b0);
        if (vld_cnt > base) begin
            d = vld_cyc[base] - last_start;
            check("t1_latency_ok", (d >= LAT - 1 && d <= LAT + 1), 1'b1);
        end

        // 2: back-to-back 0xA3, 0x0F
        base = vld_cnt;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        tick(4);
        check("t2_count", vld_cnt - base, 2);
        if (vld_cnt >= base + 2) begin
            check("t2_data0", vld_q[base], 8'hA3);
            check("t2_data1", vld_q[base+1], 8'h0F);
            check("t2_spacing", vld_cyc[base+1] - vld_cyc[base], NBITS * CPB);
        end

        // 3: 4-clock glitch
        base = vld_cnt;
        max_busy = 0;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(30);
        check("t3_busy_seen", (max_busy > 0), 1'b1);
        check("t3_busy_short", (max_busy < CPB / 2 + 3), 1'b1);
        check("t3_no_valid", vld_cnt - base, 0);
        check("t3_no_ferr", ferr_cnt, 0);
        check("t3_idle", rx_busy, 1'b0);

        // 4: framing error and break
        base = vld_cnt;
        send_frame(8'h12, 1'b1);
        tick(2);
        check("t4_good", rx_data, 8'h12);
        send_frame(8'hFF, 1'b0);
        tick(20 * CPB);
        check("t4_hold_data", rx_data, 8'h12);
        check("t4_break_busy", rx_busy, 1'b1);
        tick(20 * CPB);
        check("t4_ferr_once", ferr_cnt, 1);
        rxd = 1'b1;
        tick(2 * CPB);
        check("t4_data_kept", rx_data, 8'h12);
        send_frame(8'h34, 1'b1);
        tick(4);
        check("t4_ferr_final", ferr_cnt, 1);
        check("t4_count", vld_cnt - base, 2);
        check("t4_data", rx_data, 8'h34);

        // 5: reset during bit 4 of 0x3C
        base = vld_cnt;
        b3c = 8'h3C;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = b3c[i];
            tick(CPB);
        end
        rxd = b3c[4];
        tick(CPB / 2);
        n_rst = 1'b0;
        rxd = 1'b1;
        #2;
        check("t5_rst_data", rx_data, 8'h00);
        check("t5_rst_busy", rx_busy, 1'b0);
        check("t5_rst_valid", rx_valid, 1'b0);
        check("t5_rst_ferr", frame_err, 1'b0);
        tick(5);
        n_rst = 1'b1;
        tick(3 * CPB);
        check("t5_no_pulse", vld_cnt - base, 0);
        send_frame(8'hC3, 1'b1);
        tick(4);
        check("t5_count", vld_cnt - base, 1);
        check("t5_data", rx_data, 8'hC3);

`ifdef RX_PARITY_EN
        // 6: parity
        base = vld_cnt;
        send_frame_p(8'h07, 1'b0);
        tick(4);
        check("t6_perr", perr_cnt, 1);
        check("t6_no_valid", vld_cnt - base, 0);
        check("t6_data_kept", rx_data, 8'hC3);
        send_frame_p(8'h07, 1'b1);
        tick(4);
        check("t6_valid", vld_cnt - base, 1);
        check("t6_data", rx_data, 8'h07);
        check("t6_perr_final", perr_cnt, 1);
`endif

        check("pulse_exclusive", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
